// File: rtl/vga_timing_ctrl.sv
// VGA raster timing generator: a one-cycle pixel-enable tick drives horizontal and vertical phase FSMs.
// Every output comes straight from a flop, so coordinates, sync, blanking and strobes stay aligned.
module vga_timing_ctrl #(
    parameter int unsigned PIX_DIV  = 4,
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned H_FP     = 16,
    parameter int unsigned H_SYNC   = 96,
    parameter int unsigned H_BP     = 48,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned V_FP     = 10,
    parameter int unsigned V_SYNC   = 2,
    parameter int unsigned V_BP     = 33,
    parameter bit          SYNC_POL = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    output logic       hsync,
    output logic       vsync,
    output logic       video_on,
    output logic [9:0] pix_x,
    output logic [9:0] pix_y,
    output logic       pix_tick,
    output logic       line_start,
    output logic       frame_start
);

    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int unsigned DIV_W   = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;

    localparam logic [DIV_W-1:0] DIV_ZERO = DIV_W'(0);
    localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(PIX_DIV - 1);

    localparam logic [9:0] CNT_ZERO    = 10'd0;
    localparam logic [9:0] CNT_ONE     = 10'd1;
    localparam logic [9:0] H_ACT_LAST  = 10'(H_ACTIVE - 1);
    localparam logic [9:0] H_FP_LAST   = 10'(H_ACTIVE + H_FP - 1);
    localparam logic [9:0] H_SYNC_LAST = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [9:0] H_LAST      = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_ACT_LAST  = 10'(V_ACTIVE - 1);
    localparam logic [9:0] V_FP_LAST   = 10'(V_ACTIVE + V_FP - 1);
    localparam logic [9:0] V_SYNC_LAST = 10'(V_ACTIVE + V_FP + V_SYNC - 1);
    localparam logic [9:0] V_LAST      = 10'(V_TOTAL - 1);

    localparam logic SYNC_ON  = SYNC_POL;
    localparam logic SYNC_OFF = ~SYNC_POL;

    typedef enum logic [1:0] {
        ST_ACT   = 2'd0,
        ST_FRONT = 2'd1,
        ST_SYNC  = 2'd2,
        ST_BACK  = 2'd3
    } phase_e;

    // One phase step, shared by both axes: leave a phase on its last count.
    function automatic phase_e next_phase(
        input phase_e     st,
        input logic [9:0] cnt,
        input logic [9:0] act_last,
        input logic [9:0] fp_last,
        input logic [9:0] sync_last,
        input logic [9:0] last
    );
        phase_e nxt;
        nxt = st;
        case (st)
            ST_ACT: begin
                if (cnt == act_last) nxt = ST_FRONT;
                else                 nxt = ST_ACT;
            end
            ST_FRONT: begin
                if (cnt == fp_last) nxt = ST_SYNC;
                else                nxt = ST_FRONT;
            end
            ST_SYNC: begin
                if (cnt == sync_last) nxt = ST_BACK;
                else                  nxt = ST_SYNC;
            end
            ST_BACK: begin
                if (cnt == last) nxt = ST_ACT;
                else             nxt = ST_BACK;
            end
            default: nxt = ST_ACT;
        endcase
        return nxt;
    endfunction

    logic [DIV_W-1:0] div_q, div_d;
    logic [9:0]       h_cnt_q, h_cnt_d;
    logic [9:0]       v_cnt_q, v_cnt_d;
    phase_e           h_st_q, h_st_d;
    phase_e           v_st_q, v_st_d;
    logic             hsync_q, hsync_d;
    logic             vsync_q, vsync_d;
    logic             video_on_q, video_on_d;
    logic             tick_q, tick_d;
    logic             line_start_q, line_start_d;
    logic             frame_start_q, frame_start_d;

    logic run_s;
    logic adv_s;
    logic h_wrap_s;
    logic v_wrap_s;

    assign run_s    = en & ~rst;
    assign adv_s    = (div_q == DIV_LAST);
    assign h_wrap_s = adv_s & (h_cnt_q == H_LAST);
    assign v_wrap_s = h_wrap_s & (v_cnt_q == V_LAST);

    // Divider and raster counters; a stopped or reset timer parks at the origin.
    always_comb begin
        div_d   = div_q;
        h_cnt_d = h_cnt_q;
        v_cnt_d = v_cnt_q;
        if (!run_s) begin
            div_d   = DIV_ZERO;
            h_cnt_d = CNT_ZERO;
            v_cnt_d = CNT_ZERO;
        end else if (adv_s) begin
            div_d = DIV_ZERO;
            if (h_wrap_s) begin
                h_cnt_d = CNT_ZERO;
                if (v_wrap_s) v_cnt_d = CNT_ZERO;
                else          v_cnt_d = v_cnt_q + CNT_ONE;
            end else begin
                h_cnt_d = h_cnt_q + CNT_ONE;
                v_cnt_d = v_cnt_q;
            end
        end else begin
            div_d   = div_q + DIV_ONE;
            h_cnt_d = h_cnt_q;
            v_cnt_d = v_cnt_q;
        end
    end

    // Horizontal phase steps per pixel tick, vertical phase only on the line wrap.
    always_comb begin
        h_st_d = h_st_q;
        v_st_d = v_st_q;
        if (!run_s) begin
            h_st_d = ST_ACT;
            v_st_d = ST_ACT;
        end else begin
            if (adv_s) h_st_d = next_phase(h_st_q, h_cnt_q, H_ACT_LAST, H_FP_LAST, H_SYNC_LAST, H_LAST);
            else       h_st_d = h_st_q;
            if (h_wrap_s) v_st_d = next_phase(v_st_q, v_cnt_q, V_ACT_LAST, V_FP_LAST, V_SYNC_LAST, V_LAST);
            else          v_st_d = v_st_q;
        end
    end

    // Outputs are decoded from next state so they land on the same edge as the counters.
    always_comb begin
        hsync_d       = SYNC_OFF;
        vsync_d       = SYNC_OFF;
        video_on_d    = 1'b0;
        tick_d        = (div_d == DIV_LAST);
        line_start_d  = run_s & h_wrap_s;
        frame_start_d = run_s & v_wrap_s;
        if (h_st_d == ST_SYNC) hsync_d = SYNC_ON;
        else                   hsync_d = SYNC_OFF;
        if (v_st_d == ST_SYNC) vsync_d = SYNC_ON;
        else                   vsync_d = SYNC_OFF;
        if (run_s && (h_st_d == ST_ACT) && (v_st_d == ST_ACT)) video_on_d = 1'b1;
        else                                                   video_on_d = 1'b0;
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            div_q         <= DIV_ZERO;
            h_cnt_q       <= CNT_ZERO;
            v_cnt_q       <= CNT_ZERO;
            h_st_q        <= ST_ACT;
            v_st_q        <= ST_ACT;
            hsync_q       <= SYNC_OFF;
            vsync_q       <= SYNC_OFF;
            video_on_q    <= 1'b0;
            tick_q        <= (DIV_LAST == DIV_ZERO);
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            div_q         <= div_d;
            h_cnt_q       <= h_cnt_d;
            v_cnt_q       <= v_cnt_d;
            h_st_q        <= h_st_d;
            v_st_q        <= v_st_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            video_on_q    <= video_on_d;
            tick_q        <= tick_d;
            line_start_q  <= line_start_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign video_on    = video_on_q;
    assign pix_x       = h_cnt_q;
    assign pix_y       = v_cnt_q;
    assign pix_tick    = tick_q;
    assign line_start  = line_start_q;
    assign frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_timing_ctrl.sv
// Bench for vga_timing_ctrl: a tiny-raster instance and a full-width/short-frame instance, each
// tracked cycle by cycle against a counter-range model, plus directed timing measurements.
module tb_vga_timing_ctrl;

    typedef struct packed {
        logic       hs;
        logic       vs;
        logic       von;
        logic       tick;
        logic       ls;
        logic       fs;
        logic [9:0] x;
        logic [9:0] y;
    } obs_t;

    typedef struct packed {
        int div; int ha; int hf; int hsw; int hb;
        int va;  int vf; int vsw; int vb; bit pol;
    } cfg_t;

    typedef struct { int div; int h; int v; } mst_t;

    localparam cfg_t CFG_S = '{div:1, ha:4, hf:1, hsw:2, hb:1, va:3, vf:1, vsw:1, vb:1, pol:1'b1};
    localparam cfg_t CFG_C = '{div:4, ha:640, hf:16, hsw:96, hb:48, va:1, vf:1, vsw:2, vb:1, pol:1'b0};

    logic clk = 1'b0;
    logic rst_s, en_s, rst_c, en_c;
    logic hs_s, vs_s, von_s, tick_s, ls_s, fs_s;
    logic hs_c, vs_c, von_c, tick_c, ls_c, fs_c;
    logic [9:0] x_s, y_s, x_c, y_c;
    obs_t obs_s, obs_c;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    mst_t mst_s, mst_c;
    obs_t sbq_s[$];
    obs_t sbq_c[$];

    always #5 clk = ~clk;

    vga_timing_ctrl #(
        .PIX_DIV(1), .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
        .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1), .SYNC_POL(1'b1)
    ) dut_s (
        .clk(clk), .rst(rst_s), .en(en_s), .hsync(hs_s), .vsync(vs_s), .video_on(von_s),
        .pix_x(x_s), .pix_y(y_s), .pix_tick(tick_s), .line_start(ls_s), .frame_start(fs_s)
    );

    vga_timing_ctrl #(
        .PIX_DIV(4), .H_ACTIVE(640), .H_FP(16), .H_SYNC(96), .H_BP(48),
        .V_ACTIVE(1), .V_FP(1), .V_SYNC(2), .V_BP(1), .SYNC_POL(1'b0)
    ) dut_c (
        .clk(clk), .rst(rst_c), .en(en_c), .hsync(hs_c), .vsync(vs_c), .video_on(von_c),
        .pix_x(x_c), .pix_y(y_c), .pix_tick(tick_c), .line_start(ls_c), .frame_start(fs_c)
    );

    assign obs_s = {hs_s, vs_s, von_s, tick_s, ls_s, fs_s, x_s, y_s};
    assign obs_c = {hs_c, vs_c, von_c, tick_c, ls_c, fs_c, x_c, y_c};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
        end
    endtask

    // Reference: plain counters; sync and blanking come from count ranges, not phases.
    function automatic void model_step(input cfg_t c, input bit run, input mst_t st,
                                       output mst_t nst, output obs_t e);
        int  ht, vt;
        bit  tk;
        ht  = c.ha + c.hf + c.hsw + c.hb;
        vt  = c.va + c.vf + c.vsw + c.vb;
        nst = st;
        e   = '0;
        if (!run) begin
            nst.div = 0; nst.h = 0; nst.v = 0;
        end else begin
            tk = (st.div == c.div - 1);
            nst.div = tk ? 0 : st.div + 1;
            if (tk) begin
                if (st.h == ht - 1) begin
                    nst.h = 0;
                    e.ls  = 1'b1;
                    if (st.v == vt - 1) begin
                        nst.v = 0;
                        e.fs  = 1'b1;
                    end else begin
                        nst.v = st.v + 1;
                    end
                end else begin
                    nst.h = st.h + 1;
                end
            end
            e.von = (nst.h < c.ha) && (nst.v < c.va);
        end
        e.x    = 10'(nst.h);
        e.y    = 10'(nst.v);
        e.tick = (nst.div == c.div - 1);
        e.hs   = ((nst.h >= c.ha + c.hf) && (nst.h < c.ha + c.hf + c.hsw)) ? c.pol : !c.pol;
        e.vs   = ((nst.v >= c.va + c.vf) && (nst.v < c.va + c.vf + c.vsw)) ? c.pol : !c.pol;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard: predict at the edge from the inputs just sampled, compare once outputs settle.
    always @(posedge clk) begin
        mst_t ns_s, ns_c;
        obs_t e_s, e_c;
        model_step(CFG_S, !rst_s && en_s, mst_s, ns_s, e_s);
        model_step(CFG_C, !rst_c && en_c, mst_c, ns_c, e_c);
        mst_s <= ns_s;
        mst_c <= ns_c;
        sbq_s.push_back(e_s);
        sbq_c.push_back(e_c);
        #1;
        check("sb_small", 32'(obs_s), 32'(sbq_s.pop_front()));
        check("sb_wide", 32'(obs_c), 32'(sbq_c.pop_front()));
    end

    function automatic bit evt(input int sel);
        bit r;
        case (sel)
            0:       r = fs_s;
            1:       r = fs_c;
            2:       r = ls_c;
            3:       r = tick_c;
            4:       r = (x_c == 10'd700) && (y_c == 10'd3);
            5:       r = !hs_c;
            6:       r = hs_c;
            default: r = 1'b0;
        endcase
        return r;
    endfunction

    task automatic wait_evt(input int sel, input int limit, output int vons);
        int n;
        bit hit;
        n    = 0;
        hit  = 1'b0;
        vons = 0;
        while (!hit && n < limit) begin
            @(negedge clk);
            n++;
            if (von_c && tick_c) vons++;
            hit = evt(sel);
        end
        n_vec++;
        assert (hit) else begin
            n_err++;
            $error("FAIL wait_evt%0d: event not seen within %0d clk, required within bound", sel, limit);
        end
    endtask

    initial begin
        int   t0, t1, t2, t, vons;
        obs_t rst_exp_s, rst_exp_c;
        mst_s = '{0, 0, 0};
        mst_c = '{0, 0, 0};
        rst_exp_s      = '0;
        rst_exp_s.tick = 1'b1;
        rst_exp_c      = '0;
        rst_exp_c.hs   = 1'b1;
        rst_exp_c.vs   = 1'b1;

        rst_s = 1'b1; en_s = 1'b1; rst_c = 1'b1; en_c = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_small", 32'(obs_s), 32'(rst_exp_s));
        check("reset_wide", 32'(obs_c), 32'(rst_exp_c));

        rst_s = 1'b0; rst_c = 1'b0;
        t0 = cyc;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            check("small_x_seq", 32'(x_s), 32'((i + 1) % 8));
        end
        wait_evt(0, 200, vons);
        check("small_first_frame", 32'(cyc - t0), 32'd48);
        t = cyc;
        wait_evt(0, 200, vons);
        check("small_frame_period", 32'(cyc - t), 32'd48);

        wait_evt(2, 4000, vons);
        check("first_line_start", 32'(cyc - t0), 32'd3200);
        check("line1_y", 32'(y_c), 32'd1);
        check("line1_vsync", 32'(vs_c), 32'd1);
        t = cyc;
        wait_evt(2, 4000, vons);
        check("line_period", 32'(cyc - t), 32'd3200);
        check("line2_y", 32'(y_c), 32'd2);
        check("line2_vsync", 32'(vs_c), 32'd0);
        wait_evt(5, 4000, vons);
        check("hsync_fall_x", 32'(x_c), 32'd656);
        t = cyc;
        wait_evt(6, 4000, vons);
        check("hsync_low_clks", 32'(cyc - t), 32'd384);

        wait_evt(4, 20000, vons);
        check("pre_rst_syncs", 32'({hs_c, vs_c}), 32'd0);
        rst_c = 1'b1; rst_s = 1'b1;
        @(negedge clk);
        check("mid_sync_reset", 32'(obs_c), 32'(rst_exp_c));
        rst_c = 1'b0; rst_s = 1'b0;
        t1 = cyc;
        wait_evt(3, 20, vons);
        check("first_tick_delay", 32'(cyc - t1), 32'd3);
        check("first_tick_x", 32'(x_c), 32'd0);
        @(negedge clk);
        check("first_advance_x", 32'(x_c), 32'd1);
        wait_evt(1, 20000, vons);
        check("restart_frame", 32'(cyc - t1), 32'd16000);
        t = cyc;
        wait_evt(1, 20000, vons);
        check("frame_period", 32'(cyc - t), 32'd16000);
        check("video_ticks_frame", 32'(vons), 32'd640);

        repeat (1200) @(negedge clk);
        en_c = 1'b0; en_s = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            check("en_hold", 32'(obs_c), 32'(rst_exp_c));
        end
        en_c = 1'b1; en_s = 1'b1;
        t2 = cyc;
        wait_evt(1, 20000, vons);
        check("en_restart_frame", 32'(cyc - t2), 32'd16000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
